// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  borrow
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a single borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] r;
  logic             br;
  logic [CW-1:0]    count;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
  logic             ovf_reg;
`endif

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] r_next;

  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    r_next  = {d, r[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      sa         <= '0;
      sb         <= '0;
      r          <= '0;
      br         <= 1'b0;
      count      <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf_reg    <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            sa       <= bus.a;
            sb       <= bus.b;
            br       <= 1'b0;
            count    <= '0;
            busy_reg <= 1'b1;
            state    <= StShift;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.b[WIDTH-1];
`endif
          end
        end
        StShift: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          r     <= r_next;
          br    <= br_next;
          count <= count + CW'(1);
          // Last bit: publish the result including the bit computed this edge.
          if (count == LastCount) begin
            diff_reg   <= r_next;
            borrow_reg <= br_next;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state      <= StIdle;
`ifdef SERIAL_SUB_OVF_EN
            ovf_reg    <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.diff   = diff_reg;
  assign bus.borrow = borrow_reg;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_reg;
`endif

endmodule
